// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and types for the key sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    EMIT    = 3'd4
  } state_t;

  typedef enum logic {
    MAKE  = 1'b0,
    BREAK = 1'b1
  } ev_t;

  // 00 and FF are receiver filler/error bytes, never key codes.
  function automatic logic is_junk(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Watchdog for the gap between a prefix byte and its follow-up byte.
module ps2_prefix_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  assign expire = run && (r_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      r_cnt <= '0;
    end else if (!expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns the PS/2 scan-code byte stream into press/repeat/release events
// and tracks the held key for the display datapath.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_held,
  output logic               press_pulse,
  output logic               repeat_pulse,
  output logic               release_pulse,
  output logic [COUNT_W-1:0] press_count,
  output logic               err_pulse
);

  state_t     r_state;
  logic [7:0] r_pend_code;
  logic       r_pend_ext;
  ev_t        r_pend_type;

  logic w_xfer;
  logic w_run;
  logic w_expire;
  logic w_junk;
  logic w_match;

  assign w_xfer  = in_valid && in_ready;
  assign w_run   = (r_state == EXT) || (r_state == BRK) || (r_state == EXT_BRK);
  assign w_junk  = is_junk(in_data);
  assign w_match = key_held && (r_pend_code == key_code) && (r_pend_ext == key_ext);

  ps2_prefix_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (w_xfer),
    .run   (w_run),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pend_code   <= '0;
      r_pend_ext    <= 1'b0;
      r_pend_type   <= MAKE;
      in_ready      <= 1'b1;
      key_code      <= '0;
      key_ext       <= 1'b0;
      key_held      <= 1'b0;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
      err_pulse     <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      err_pulse     <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (in_data == PS2_EXT) begin
              r_state <= EXT;
            end else if (in_data == PS2_BRK) begin
              r_state <= BRK;
            end else if (!w_junk) begin
              r_pend_code <= in_data;
              r_pend_ext  <= 1'b0;
              r_pend_type <= MAKE;
              r_state     <= EMIT;
              in_ready    <= 1'b0;
            end
          end
        end

        EXT: begin
          if (w_xfer) begin
            if (in_data == PS2_BRK) begin
              r_state <= EXT_BRK;
            end else if (w_junk || (in_data == PS2_EXT)) begin
              err_pulse <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_pend_code <= in_data;
              r_pend_ext  <= 1'b1;
              r_pend_type <= MAKE;
              r_state     <= EMIT;
              in_ready    <= 1'b0;
            end
          end else if (w_expire) begin
            err_pulse <= 1'b1;
            r_state   <= IDLE;
          end
        end

        BRK, EXT_BRK: begin
          if (w_xfer) begin
            if (w_junk || (in_data == PS2_EXT) || (in_data == PS2_BRK)) begin
              err_pulse <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_pend_code <= in_data;
              r_pend_ext  <= (r_state == EXT_BRK);
              r_pend_type <= BREAK;
              r_state     <= EMIT;
              in_ready    <= 1'b0;
            end
          end else if (w_expire) begin
            err_pulse <= 1'b1;
            r_state   <= IDLE;
          end
        end

        EMIT: begin
          // Commit the pending event against the held-key registers.
          r_state  <= IDLE;
          in_ready <= 1'b1;
          if (r_pend_type == MAKE) begin
            if (w_match) begin
              repeat_pulse <= 1'b1;
            end else begin
              key_code    <= r_pend_code;
              key_ext     <= r_pend_ext;
              key_held    <= 1'b1;
              press_pulse <= 1'b1;
              press_count <= press_count + COUNT_W'(1);
            end
          end else if (w_match) begin
            key_held      <= 1'b0;
            release_pulse <= 1'b1;
          end
        end

        default: begin
          r_state  <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench: a byte-level model pushes expected events as bytes are
// accepted; every pulse seen from the sequencer pops and checks one event.
module tb_ps2_key_sequencer;

  localparam int unsigned COUNT_W     = 8;
  localparam int unsigned TIMEOUT_CYC = 1024;

  localparam int K_PRESS   = 0;
  localparam int K_REPEAT  = 1;
  localparam int K_RELEASE = 2;
  localparam int K_ERR     = 3;

  typedef struct {
    int                 kind;
    logic [7:0]         code;
    logic               ext;
    logic               held;
    logic [COUNT_W-1:0] count;
  } exp_t;

  logic               clk;
  logic               rst;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         key_code;
  logic               key_ext;
  logic               key_held;
  logic               press_pulse;
  logic               repeat_pulse;
  logic               release_pulse;
  logic [COUNT_W-1:0] press_count;
  logic               err_pulse;

  ps2_key_sequencer #(
    .COUNT_W    (COUNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_held     (key_held),
    .press_pulse  (press_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count),
    .err_pulse    (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_press = 0, n_repeat = 0, n_release = 0, n_err = 0;
  int stalls;

  exp_t       sb[$];
  logic [7:0] tx_q[$];

  int                 m_st;
  logic [7:0]         m_code;
  logic               m_ext;
  logic               m_held;
  logic [COUNT_W-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind);
    exp_t e;
    e.kind  = kind;
    e.code  = m_code;
    e.ext   = m_ext;
    e.held  = m_held;
    e.count = m_cnt;
    sb.push_back(e);
  endtask

  task automatic model_make(input logic [7:0] b, input logic ext);
    if (m_held && (b == m_code) && (ext == m_ext)) begin
      push_ev(K_REPEAT);
    end else begin
      m_code = b;
      m_ext  = ext;
      m_held = 1'b1;
      m_cnt  = m_cnt + COUNT_W'(1);
      push_ev(K_PRESS);
    end
  endtask

  task automatic model_break(input logic [7:0] b, input logic ext);
    if (m_held && (b == m_code) && (ext == m_ext)) begin
      m_held = 1'b0;
      push_ev(K_RELEASE);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic junk;
    junk = (b == 8'h00) || (b == 8'hFF);
    case (m_st)
      0: begin
        if (b == 8'hE0) m_st = 1;
        else if (b == 8'hF0) m_st = 2;
        else if (!junk) model_make(b, 1'b0);
      end
      1: begin
        if (b == 8'hF0) begin
          m_st = 3;
        end else begin
          if (junk || (b == 8'hE0)) push_ev(K_ERR);
          else model_make(b, 1'b1);
          m_st = 0;
        end
      end
      default: begin
        if (junk || (b == 8'hE0) || (b == 8'hF0)) push_ev(K_ERR);
        else model_break(b, m_st == 3);
        m_st = 0;
      end
    endcase
  endtask

  // Advance to the next falling edge and score any pulse present there.
  task automatic tick();
    int np;
    int kind;
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      np = int'(press_pulse) + int'(repeat_pulse) + int'(release_pulse) + int'(err_pulse);
      if (np > 1) check_eq("one_hot", 32'(np), 32'd1);
      if (np != 0) begin
        kind = press_pulse ? K_PRESS : repeat_pulse ? K_REPEAT : release_pulse ? K_RELEASE : K_ERR;
        if (kind == K_PRESS) n_press++;
        else if (kind == K_REPEAT) n_repeat++;
        else if (kind == K_RELEASE) n_release++;
        else n_err++;
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", 32'(kind), 32'd99);
        end else begin
          e = sb.pop_front();
          check_eq("ev_kind", 32'(kind), 32'(e.kind));
          check_eq("ev_code", 32'(key_code), 32'(e.code));
          check_eq("ev_ext", 32'(key_ext), 32'(e.ext));
          check_eq("ev_held", 32'(key_held), 32'(e.held));
          check_eq("ev_count", 32'(press_count), 32'(e.count));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drains tx_q with in_valid held high; called at a falling edge.
  task automatic send_q();
    int wait_cnt;
    stalls   = 0;
    wait_cnt = 0;
    while (tx_q.size() > 0) begin
      in_data  = tx_q[0];
      in_valid = 1'b1;
      if (in_ready) begin
        model_byte(tx_q.pop_front());
        wait_cnt = 0;
      end else begin
        stalls++;
        wait_cnt++;
        if (wait_cnt > 8) begin
          check_eq("ready_timeout", 32'(in_ready), 32'd1);
          tx_q.delete();
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Reset with a byte offered at the same time; it must be ignored.
  task automatic do_reset();
    in_data  = 8'h75;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    tick();
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_code", 32'(key_code), 32'd0);
    check_eq("rst_ext", 32'(key_ext), 32'd0);
    check_eq("rst_held", 32'(key_held), 32'd0);
    check_eq("rst_count", 32'(press_count), 32'd0);
    check_eq("rst_pulses", 32'({press_pulse, repeat_pulse, release_pulse, err_pulse}), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    m_st = 0; m_code = 8'h00; m_ext = 1'b0; m_held = 1'b0; m_cnt = '0;
    tick();
  endtask

  initial begin
    int b_press, b_repeat, b_release, b_err, found;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    do_reset();

    // Typematic repeats then release.
    b_press = n_press; b_repeat = n_repeat; b_release = n_release;
    tx_q = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    send_q();
    check_eq("t1_stalls", 32'(stalls), 32'd3);
    idle(4);
    check_eq("t1_press", 32'(n_press - b_press), 32'd1);
    check_eq("t1_repeat", 32'(n_repeat - b_repeat), 32'd2);
    check_eq("t1_release", 32'(n_release - b_release), 32'd1);
    check_eq("t1_count", 32'(press_count), 32'd1);
    check_eq("t1_code", 32'(key_code), 32'h1C);
    check_eq("t1_held", 32'(key_held), 32'd0);

    // Extended make and extended break.
    tx_q = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    send_q();
    idle(4);
    check_eq("t2_ext", 32'(key_ext), 32'd1);
    check_eq("t2_code", 32'(key_code), 32'h75);
    check_eq("t2_held", 32'(key_held), 32'd0);

    // Rollover to a new key; break of the old key is ignored.
    b_release = n_release;
    tx_q = '{8'h1C, 8'h32, 8'hF0, 8'h1C};
    send_q();
    idle(4);
    check_eq("t3_code", 32'(key_code), 32'h32);
    check_eq("t3_held", 32'(key_held), 32'd1);
    check_eq("t3_release", 32'(n_release - b_release), 32'd0);

    // Filler in IDLE is dropped; illegal bytes after a prefix are errors.
    b_err = n_err;
    tx_q = '{8'hFF, 8'h00, 8'hE0, 8'h00, 8'hF0, 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'hF0, 8'hFF};
    send_q();
    idle(4);
    check_eq("ill_err", 32'(n_err - b_err), 32'd5);
    check_eq("ill_held", 32'(key_held), 32'd1);

    // Prefix timeout lands exactly TIMEOUT_CYC cycles after the prefix.
    tx_q = '{8'hF0};
    send_q();
    push_ev(K_ERR);
    m_st  = 0;
    found = 0;
    for (int i = 1; i <= TIMEOUT_CYC + 64; i++) begin
      tick();
      if (err_pulse && found == 0) found = i;
    end
    check_eq("to_cycle", 32'(found), 32'(TIMEOUT_CYC));
    tx_q = '{8'h1C};
    send_q();
    idle(4);
    check_eq("to_press_code", 32'(key_code), 32'h1C);

    // A byte arriving on the expiry edge wins over the timeout.
    b_err = n_err; b_release = n_release;
    tx_q = '{8'hF0};
    send_q();
    idle(TIMEOUT_CYC - 1);
    tx_q = '{8'h1C};
    send_q();
    idle(4);
    check_eq("edge_err", 32'(n_err - b_err), 32'd0);
    check_eq("edge_release", 32'(n_release - b_release), 32'd1);

    // Back-to-back makes with in_valid held: exactly one stall cycle.
    tx_q = '{8'h1C, 8'h32};
    send_q();
    check_eq("t6_stalls", 32'(stalls), 32'd1);
    idle(4);
    check_eq("t6_code", 32'(key_code), 32'h32);

    // Reset in EXT drops the prefix.
    tx_q = '{8'hE0};
    send_q();
    do_reset();
    tx_q = '{8'h75};
    send_q();
    idle(4);
    check_eq("t6r_ext", 32'(key_ext), 32'd0);
    check_eq("t6r_count", 32'(press_count), 32'd1);

    // Press counter wraps from all-ones to zero.
    do_reset();
    b_err = n_err;
    for (int i = 0; i < 255; i++) tx_q.push_back((i % 2 == 1) ? 8'h16 : 8'h15);
    send_q();
    idle(4);
    check_eq("t5_ff", 32'(press_count), 32'hFF);
    tx_q = '{8'h16};
    send_q();
    idle(4);
    check_eq("t5_wrap", 32'(press_count), 32'h00);
    check_eq("t5_err", 32'(n_err - b_err), 32'd0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
